// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch -- instruction fetch unit with a held instruction register.
//
// Fetches one instruction at a time from instruction memory. The IR is held
// until downstream consumes it, and then the next pc is selected:
// jump > taken branch > pc+4.
//
// Parameters
//   RESET_PC        pc value loaded on reset
//   TIMEOUT_CYCLES  fetch watchdog limit (only with FETCH_TIMEOUT_EN)
//
// Ports
//   clk         clock, rising edge
//   resetN      asynchronous active-low reset
//   imemReq     instruction-memory read request
//   imemAddr    byte address of the requested instruction (= pc)
//   imemRdata   returned instruction word
//   imemValid   imemRdata valid this cycle
//   instr       held instruction register
//   opCode      instr[31:27]
//   instrValid  IR holds an unconsumed instruction
//   advance     downstream consumes IR this cycle
//   branch      branch decode for the held instruction
//   jump        jump decode for the held instruction
//   zero        ALU zero flag for the held instruction
//   pc          address of the held or in-flight instruction
//   fetchErr    one-cycle pulse on fetch timeout
//
// Build option
//   FETCH_TIMEOUT_EN  when defined, a watchdog pulses fetchErr after
//                     TIMEOUT_CYCLES fetch cycles without imemValid;
//                     otherwise fetchErr is tied to 0.
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        resetN,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic [31:0] imemRdata,
  input  logic        imemValid,
  output logic [31:0] instr,
  output logic [4:0]  opCode,
  output logic        instrValid,
  input  logic        advance,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] pc,
  output logic        fetchErr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  // A zero watchdog limit is meaningless; reject it at elaboration.
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("instr_fetch: TIMEOUT_CYCLES must be at least 1");
  end

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_instr_valid;
  logic        r_imem_req;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_target;
  logic [31:0] w_jmp_target;
  logic [31:0] w_pc_next;

  // Next-pc selection; jump has priority over a taken branch.
  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_br_target  = w_pc_plus4 + {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  assign w_jmp_target = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};

  always_comb begin
    w_pc_next = w_pc_plus4;
    if (jump) begin
      w_pc_next = w_jmp_target;
    end else if (branch && zero) begin
      w_pc_next = w_br_target;
    end
  end

  // Fetch FSM with registered request / valid outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_instr       <= 32'h0;
      r_instr_valid <= 1'b0;
      r_imem_req    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state    <= S_FETCH;
          r_imem_req <= 1'b1;
        end
        S_FETCH: begin
          if (imemValid) begin
            r_instr       <= imemRdata;
            r_state       <= S_HOLD;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b1;
          end
        end
        S_HOLD: begin
          // branch/jump/zero only matter on the consuming edge
          if (advance) begin
            r_pc          <= w_pc_next;
            r_state       <= S_FETCH;
            r_imem_req    <= 1'b1;
            r_instr_valid <= 1'b0;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_wdog_cnt;
  logic [CNT_W-1:0] w_wdog_next;
  logic             r_fetch_err;

  assign w_wdog_next = (r_wdog_cnt == CNT_MAX) ? '0 : r_wdog_cnt + CNT_W'(1);

  // Watchdog: fetchErr is high in the cycle the count sits at its limit;
  // the request stays up at the same address.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_wdog_cnt  <= '0;
      r_fetch_err <= 1'b0;
    end else if ((r_state == S_FETCH) && !imemValid) begin
      r_wdog_cnt  <= w_wdog_next;
      r_fetch_err <= (w_wdog_next == CNT_MAX);
    end else begin
      r_wdog_cnt  <= '0;
      r_fetch_err <= 1'b0;
    end
  end

  assign fetchErr = r_fetch_err;
`else
  assign fetchErr = 1'b0;
`endif

  assign imemReq    = r_imem_req;
  assign imemAddr   = r_pc;
  assign pc         = r_pc;
  assign instr      = r_instr;
  assign opCode     = r_instr[31:27];
  assign instrValid = r_instr_valid;

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch -- self-checking bench for instr_fetch.
// Per-cycle vector table for the main fetch/next-pc behaviour, then
// hand-written sequences for reset mid-fetch, the watchdog and a jump from
// a high address (second instance with a non-zero RESET_PC).
// ---------------------------------------------------------------------------
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        resetN;
  logic        resetN_hi;
  logic [31:0] imemRdata;
  logic        imemValid;
  logic        advance, branch, jump, zero;

  logic        imemReq, instrValid, fetchErr;
  logic [31:0] imemAddr, instr, pc;
  logic [4:0]  opCode;

  logic        hi_req, hi_iv, hi_err;
  logic [31:0] hi_addr, hi_instr, hi_pc;
  logic [4:0]  hi_op;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_fetch u_dut (
    .clk(clk), .resetN(resetN), .imemReq(imemReq), .imemAddr(imemAddr),
    .imemRdata(imemRdata), .imemValid(imemValid), .instr(instr),
    .opCode(opCode), .instrValid(instrValid), .advance(advance),
    .branch(branch), .jump(jump), .zero(zero), .pc(pc), .fetchErr(fetchErr)
  );

  instr_fetch #(.RESET_PC(32'h4000_0000)) u_dut_hi (
    .clk(clk), .resetN(resetN_hi), .imemReq(hi_req), .imemAddr(hi_addr),
    .imemRdata(imemRdata), .imemValid(imemValid), .instr(hi_instr),
    .opCode(hi_op), .instrValid(hi_iv), .advance(advance),
    .branch(branch), .jump(jump), .zero(zero), .pc(hi_pc), .fetchErr(hi_err)
  );

  typedef struct {
    logic        rst_n;
    logic        vld;
    logic [31:0] rdata;
    logic        adv, br, jmp, zr;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic rst_n, logic vld, logic [31:0] rdata,
                              logic adv, logic br, logic jmp, logic zr,
                              logic e_req, logic [31:0] e_addr, logic e_iv,
                              logic [31:0] e_instr, logic [31:0] e_pc);
    vec_t v;
    v.rst_n = rst_n; v.vld = vld; v.rdata = rdata;
    v.adv = adv; v.br = br; v.jmp = jmp; v.zr = zr;
    v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv;
    v.e_instr = e_instr; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(logic vld, logic [31:0] rdata, logic adv, logic br, logic jmp, logic zr);
    imemValid = vld; imemRdata = rdata;
    advance = adv; branch = br; jump = jmp; zero = zr;
  endtask

  initial begin
    logic [4:0] e_op;
    logic [31:0] e_fe;

    // rst vld rdata        adv br jmp zr | req addr         iv instr        pc
    vecs[0]  = mk(1,0,32'h0,        0,0,0,0, 1,32'h0,        0,32'h0,        32'h0);
    vecs[1]  = mk(1,1,32'h0800_0005,0,0,0,0, 0,32'h0,        1,32'h0800_0005,32'h0);
    vecs[2]  = mk(1,1,32'h0000_DEAD,0,1,1,1, 0,32'h0,        1,32'h0800_0005,32'h0);
    vecs[3]  = mk(1,0,32'h0,        1,0,0,0, 1,32'h4,        0,32'h0800_0005,32'h4);
    vecs[4]  = mk(1,0,32'h0,        1,0,0,0, 1,32'h4,        0,32'h0800_0005,32'h4);
    vecs[5]  = mk(1,1,32'h0000_0001,0,0,0,0, 0,32'h4,        1,32'h1,        32'h4);
    vecs[6]  = mk(1,0,32'h0,        1,0,0,0, 1,32'h8,        0,32'h1,        32'h8);
    vecs[7]  = mk(1,1,32'h0000_0002,0,0,0,0, 0,32'h8,        1,32'h2,        32'h8);
    vecs[8]  = mk(1,0,32'h0,        1,0,0,0, 1,32'hC,        0,32'h2,        32'hC);
    vecs[9]  = mk(1,1,32'h0000_0003,0,0,0,0, 0,32'hC,        1,32'h3,        32'hC);
    vecs[10] = mk(1,0,32'h0,        1,0,0,0, 1,32'h10,       0,32'h3,        32'h10);
    vecs[11] = mk(1,1,32'h1000_FFFE,0,0,0,0, 0,32'h10,       1,32'h1000_FFFE,32'h10);
    vecs[12] = mk(1,0,32'h0,        0,1,0,1, 0,32'h10,       1,32'h1000_FFFE,32'h10);
    vecs[13] = mk(1,0,32'h0,        1,1,0,1, 1,32'hC,        0,32'h1000_FFFE,32'hC);
    vecs[14] = mk(1,1,32'h0000_0004,0,0,0,0, 0,32'hC,        1,32'h4,        32'hC);
    vecs[15] = mk(1,0,32'h0,        1,0,0,0, 1,32'h10,       0,32'h4,        32'h10);
    vecs[16] = mk(1,1,32'h1000_FFFE,0,0,0,0, 0,32'h10,       1,32'h1000_FFFE,32'h10);
    vecs[17] = mk(1,0,32'h0,        1,1,0,0, 1,32'h14,       0,32'h1000_FFFE,32'h14);
    vecs[18] = mk(1,1,32'h0800_0040,0,0,0,0, 0,32'h14,       1,32'h0800_0040,32'h14);
    vecs[19] = mk(1,0,32'h0,        1,1,1,1, 1,32'h100,      0,32'h0800_0040,32'h100);
    vecs[20] = mk(0,0,32'h0,        0,0,0,0, 0,32'h0,        0,32'h0,        32'h0);
    vecs[21] = mk(1,0,32'h0,        0,0,0,0, 1,32'h0,        0,32'h0,        32'h0);
    vecs[22] = mk(1,1,32'h1000_FFFE,0,0,0,0, 0,32'h0,        1,32'h1000_FFFE,32'h0);
    vecs[23] = mk(1,0,32'h0,        1,1,0,1, 1,32'hFFFF_FFFC,0,32'h1000_FFFE,32'hFFFF_FFFC);
    vecs[24] = mk(1,1,32'h0000_0000,0,0,0,0, 0,32'hFFFF_FFFC,1,32'h0,        32'hFFFF_FFFC);
    vecs[25] = mk(1,0,32'h0,        1,0,0,0, 1,32'h0,        0,32'h0,        32'h0);

    resetN = 1'b0; resetN_hi = 1'b0;
    set_in(0, 32'h0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);

    // Reset state of both instances
    chk("rst req", 32'(imemReq), 32'h0);
    chk("rst iv", 32'(instrValid), 32'h0);
    chk("rst pc", pc, 32'h0);
    chk("rst instr", instr, 32'h0);
    chk("rst ferr", 32'(fetchErr), 32'h0);
    chk("rst hi pc", hi_pc, 32'h4000_0000);

    // Table: inputs driven at negedge, outputs checked at the next negedge
    for (int i = 0; i < NV; i++) begin
      resetN = vecs[i].rst_n;
      set_in(vecs[i].vld, vecs[i].rdata, vecs[i].adv, vecs[i].br, vecs[i].jmp, vecs[i].zr);
      tick();
      e_op = vecs[i].e_instr[31:27];
      chk($sformatf("v%0d req", i), 32'(imemReq), 32'(vecs[i].e_req));
      chk($sformatf("v%0d addr", i), imemAddr, vecs[i].e_addr);
      chk($sformatf("v%0d iv", i), 32'(instrValid), 32'(vecs[i].e_iv));
      chk($sformatf("v%0d instr", i), instr, vecs[i].e_instr);
      chk($sformatf("v%0d op", i), 32'(opCode), 32'(e_op));
      chk($sformatf("v%0d pc", i), pc, vecs[i].e_pc);
      chk($sformatf("v%0d ferr", i), 32'(fetchErr), 32'h0);
      chk($sformatf("v%0d excl", i), 32'(instrValid & imemReq), 32'h0);
    end

    // Reset while fetching at 0x20; imemValid pulses during reset and IDLE
    set_in(1, 32'h1000_0007, 0, 0, 0, 0);
    tick();
    set_in(0, 32'h0, 1, 1, 0, 1);
    tick();
    chk("r36 addr", imemAddr, 32'h20);
    chk("r36 req", 32'(imemReq), 32'h1);
    set_in(1, 32'hAAAA_5555, 0, 0, 0, 0);
    #1 resetN = 1'b0;
    #1;
    chk("r36 async pc", pc, 32'h0);
    chk("r36 async iv", 32'(instrValid), 32'h0);
    chk("r36 async req", 32'(imemReq), 32'h0);
    tick();
    imemValid = 1'b0;
    tick();
    imemValid = 1'b1;
    resetN = 1'b1;
    tick();
    chk("r36 post req", 32'(imemReq), 32'h1);
    chk("r36 post addr", imemAddr, 32'h0);
    chk("r36 post iv", 32'(instrValid), 32'h0);
    chk("r36 post instr", instr, 32'h0);
    imemValid = 1'b0;

    // Watchdog: now in FETCH cycle 1 with imemValid held low
    for (int k = 1; k <= 34; k++) begin
`ifdef FETCH_TIMEOUT_EN
      e_fe = (k == 16 || k == 32) ? 32'h1 : 32'h0;
`else
      e_fe = 32'h0;
`endif
      chk($sformatf("wd c%0d ferr", k), 32'(fetchErr), e_fe);
      chk($sformatf("wd c%0d addr", k), imemAddr, 32'h0);
      chk($sformatf("wd c%0d req", k), 32'(imemReq), 32'h1);
      tick();
    end

    // Jump with branch also taken, from pc 0x4000_0000
    resetN = 1'b0;
    resetN_hi = 1'b1;
    tick();
    chk("hi fetch addr", hi_addr, 32'h4000_0000);
    chk("hi fetch req", 32'(hi_req), 32'h1);
    set_in(1, 32'h0800_0040, 0, 0, 0, 0);
    tick();
    chk("hi hold iv", 32'(hi_iv), 32'h1);
    chk("hi hold op", 32'(hi_op), 32'h1);
    chk("hi hold pc", hi_pc, 32'h4000_0000);
    set_in(0, 32'h0, 1, 1, 1, 1);
    tick();
    chk("hi jump addr", hi_addr, 32'h4000_0100);
    chk("hi jump req", 32'(hi_req), 32'h1);
    chk("hi jump iv", 32'(hi_iv), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
